source_out_burst: RTL and testbench
===================================

# source_out_burst

Parametrised output stage for the sample source path. Write-only samples go into a FIFO that cannot push back on the source. The FIFO drains as fixed-length bursts behind a registered output with a downstream stall. The block provides a flush mode for partial bursts, overflow detection, and a negedge-registered copy of the output valid. It sits between the sample source and the downstream transfer or capture logic.

## Interface
- DW, 16, sample data width.
- DEPTH, 8, FIFO depth in words; power of two, at least 2.
- BURST, 4, words per burst; 1 ≤ BURST ≤ DEPTH.
- clk  in  1  clock, rising-edge domain; the negedge register is the only exception.
- nRST  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample present this cycle; no backpressure.
- in_data  in  DW  sample.
- out_en  in  1  enables the start of new bursts.
- flush  in  1  single-cycle request to drain a partial burst.
- out_stall  in  1  downstream not accepting; holds the output register.
- clr_ovf  in  1  clears the overflow flag.
- out_valid  out  1  out_data is valid.
- out_valid_neg  out  1  out_valid sampled on the falling edge of clk.
- out_data  out  DW  output word.
- level  out  $clog2(DEPTH)+1  words held in FIFO memory; excludes the output register.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; a write arrived while full.
- flush_done  out  1  single-cycle pulse when a flush completes.

## Operation
- Reset values: out_valid=0, out_valid_neg=0, out_data=0, level=0, full=0, overflow=0, flush_done=0, state=IDLE, flush pending flag=0, pointers=0.
- Reset mid-operation discards all contents, including any burst in flight.
- Write: in_valid && !full stores in_data at wptr, and wptr wraps modulo DEPTH.
- Write while full: the word is dropped and overflow=1.
- Overflow: clr_ovf clears it. If clr_ovf and a dropped write occur in the same cycle, overflow stays 1.
- Pop condition: state ∈ {SEND, DRAIN} && level>0 && beat count>0 && (!out_valid || !out_stall).
- On pop: out_data ← mem[rptr], out_valid ← 1, rptr wraps, beat count decrements.
- Without a pop: if out_valid && !out_stall, out_valid ← 0. While stalled, out_valid and out_data hold.
- Same-cycle write and pop leaves level unchanged.
- A flush pulse sets the pending flag; further pulses while pending or in DRAIN are absorbed.
- IDLE priority 1: pending flush with level==0 → clear pending, flush_done=1 next cycle, stay in IDLE.
- IDLE priority 2: pending flush with level>0 → DRAIN; beat count ← level snapshot; pending cleared. This ignores out_en.
- IDLE priority 3: out_en && level ≥ BURST → SEND; beat count ← BURST.
- SEND: pops BURST words, then → IDLE on the edge of the last pop.
- out_en deasserted in SEND does not abort the burst.
- DRAIN: pops exactly the snapshot count; words written during DRAIN stay queued.
- DRAIN exit: on the last pop → IDLE, and flush_done pulses in the following cycle.
- Width rules: level is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits; the beat counter is sized to DEPTH. No saturation is needed.

## Timing
- Write at edge E: level reflects it after E.
- If level reaches BURST at edge E: state=SEND after E+1, first pop at E+2, so out_valid is high from E+2.
- Unstalled bursts give out_valid high for exactly BURST consecutive cycles.
- There is a minimum one-cycle out_valid gap between consecutive bursts, since IDLE is always re-entered.
- Stalls stretch a burst; out_data is stable while out_valid && out_stall.
- out_valid_neg equals out_valid delayed by half a clock.
- flush_done is high for one cycle, one cycle after the last DRAIN pop edge.

## Structure
- Package source_out_pkg holds:
  - the state typedef enum {IDLE, SEND, DRAIN};
  - parameter-legality checks as elaboration assertions.
- Sub-module source_out_fifo_mem contains the DEPTH×DW register array, pointers and level.
  - The top level owns the FSM, the output register, the flags and the negedge register.

## Test plan
All cases use DW=16, DEPTH=8, BURST=4.
- Burst: out_en=1, write 0x0001–0x0004 on consecutive cycles → out_valid high 4 cycles carrying 0x0001..0x0004, first at 2 edges after the 4th write; level returns to 0.
- Stall: same stimulus plus out_stall=1 for 3 cycles on beat 0x0002 → 0x0002 held 4 cycles; sequence intact, no loss or duplication.
- Overflow: out_en=0, write 9 words → full=1 and level=8 after the 8th; 9th dropped, overflow=1. clr_ovf pulse → overflow=0.
- Flush: out_en=0, 3 words queued, flush pulse → DRAIN outputs 3 words, flush_done one cycle after the last pop. A write during DRAIN remains with level=1.
- Empty flush and back-to-back: flush with level=0 → flush_done next cycle, no out_valid. With 8 words and out_en=1 → two 4-word bursts separated by exactly one idle cycle.
- Reset: nRST low mid-burst → out_valid, out_valid_neg, level and overflow are 0 immediately. After release with out_en=1 and no input, no output appears. out_valid_neg trails out_valid by half a cycle throughout.

Source files
------------

// File: rtl/source_out_pkg.sv
// Shared types and parameter checks for the sample-source output stage.
package source_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN
  } state_t;

  function automatic bit params_legal(input int depth, input int burst);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (burst >= 1) && (burst <= depth);
  endfunction

endpackage

// File: rtl/source_out_fifo_mem.sv
// Sample FIFO storage: register array, wrapping pointers and fill level.
// Writes while full are ignored here; the caller must only read when level > 0.
module source_out_fifo_mem #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       wr,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          accept;

  assign full    = (level == LW'(DEPTH));
  assign accept  = wr && !full;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointer wrap relies on DEPTH being a power of two.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      level <= level + LW'(accept) - LW'(rd);
    end
  end

endmodule

// File: rtl/source_out_burst.sv
// Output stage: drains the sample FIFO as fixed-length bursts through a stallable
// output register, with partial-burst flush, sticky overflow and a negedge valid copy.
module source_out_burst
  import source_out_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  input  logic                   out_en,
  input  logic                   flush,
  input  logic                   out_stall,
  input  logic                   clr_ovf,
  output logic                   out_valid,
  output logic                   out_valid_neg,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overflow,
  output logic                   flush_done
);

  localparam int LW = $clog2(DEPTH) + 1;

  generate
    if (!params_legal(DEPTH, BURST)) begin : g_bad_params
      $error("source_out_burst: DEPTH must be a power of two >= 2 and 1 <= BURST <= DEPTH");
    end
  endgenerate

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] beats;
  logic [LW-1:0] beats_nxt;
  logic          pending;
  logic          pending_nxt;
  logic          drain_end;
  logic          drain_end_nxt;
  logic          flush_done_nxt;
  logic          pop;
  logic [DW-1:0] rd_data;

  source_out_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .nRST    (nRST),
    .wr      (in_valid),
    .wr_data (in_data),
    .rd      (pop),
    .rd_data (rd_data),
    .level   (level),
    .full    (full)
  );

  assign pop = ((state == SEND) || (state == DRAIN)) && (level != '0) &&
               (beats != '0) && (!out_valid || !out_stall);

  always_comb begin
    state_nxt      = state;
    beats_nxt      = beats;
    pending_nxt    = pending;
    drain_end_nxt  = 1'b0;
    flush_done_nxt = drain_end;

    if (flush && (state != DRAIN)) begin
      pending_nxt = 1'b1;
    end
    if (pop) begin
      beats_nxt = beats - 1'b1;
    end

    case (state)
      IDLE: begin
        if (pending && (level == '0)) begin
          pending_nxt    = 1'b0;
          flush_done_nxt = 1'b1;
        end else if (pending) begin
          state_nxt   = DRAIN;
          beats_nxt   = level;
          pending_nxt = 1'b0;
        end else if (out_en && (level >= LW'(BURST))) begin
          state_nxt = SEND;
          beats_nxt = LW'(BURST);
        end
      end
      SEND: begin
        if (pop && (beats == LW'(1))) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // Completion is announced one cycle after the final word is loaded.
        if (pop && (beats == LW'(1))) begin
          state_nxt     = IDLE;
          drain_end_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      beats      <= '0;
      pending    <= 1'b0;
      drain_end  <= 1'b0;
      flush_done <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats      <= beats_nxt;
      pending    <= pending_nxt;
      drain_end  <= drain_end_nxt;
      flush_done <= flush_done_nxt;
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
      end else if (out_valid && !out_stall) begin
        out_valid <= 1'b0;
      end
      // A dropped write wins over a same-cycle clear.
      if (in_valid && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(negedge clk or negedge nRST) begin
    if (!nRST) begin
      out_valid_neg <= 1'b0;
    end else begin
      out_valid_neg <= out_valid;
    end
  end

endmodule

// File: tb/tb_source_out_burst.sv
// Scoreboarded bench for source_out_burst: directed bursts, stall, overflow, flush and reset.
module tb_source_out_burst;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          nRST;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_en;
  logic          flush;
  logic          out_stall;
  logic          clr_ovf;
  logic          out_valid;
  logic          out_valid_neg;
  logic [DW-1:0] out_data;
  logic [3:0]    level;
  logic          full;
  logic          overflow;
  logic          flush_done;

  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q[$];

  source_out_burst #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .BURST (BURST)
  ) dut (
    .clk           (clk),
    .nRST          (nRST),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_en        (out_en),
    .flush         (flush),
    .out_stall     (out_stall),
    .clr_ovf       (clr_ovf),
    .out_valid     (out_valid),
    .out_valid_neg (out_valid_neg),
    .out_data      (out_data),
    .level         (level),
    .full          (full),
    .overflow      (overflow),
    .flush_done    (flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Scoreboard: every accepted output word must match the oldest expected word.
  always @(negedge clk) begin
    if (nRST && out_valid && !out_stall) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
      end else begin
        chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("out_valid_neg", {31'h0, out_valid_neg}, {31'h0, out_valid});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit expect_out);
    in_valid = 1'b1;
    in_data  = d;
    if (expect_out) exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (flush_done) seen = 1'b1;
    end
    chk(name, {31'h0, seen}, 32'h1);
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk(name, exp_q.size(), 32'h0);
  endtask

  initial begin
    int            cnt_v;
    int            cnt2;
    logic [9:0]    hist;

    nRST = 1'b0; in_valid = 1'b0; in_data = '0; out_en = 1'b0;
    flush = 1'b0; out_stall = 1'b0; clr_ovf = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_level", {28'h0, level}, 32'h0);
    chk("rst_full", {31'h0, full}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_flush_done", {31'h0, flush_done}, 32'h0);
    nRST = 1'b1;
    tick();

    // Basic burst: first valid two edges after the fourth write.
    out_en = 1'b1;
    for (int i = 1; i <= 4; i++) wr(DW'(i), 1'b1);
    chk("burst_level4", {28'h0, level}, 32'h4);
    chk("burst_e0_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("burst_e1_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("burst_e2_valid", {31'h0, out_valid}, 32'h1);
    chk("burst_e2_data", {16'h0, out_data}, 32'h1);
    cnt_v = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid) break;
      cnt_v++;
    end
    chk("burst_len", cnt_v, 32'd4);
    chk("burst_level0", {28'h0, level}, 32'h0);
    wait_drained("burst_drained");

    // Stall three cycles while beat 0x0002 is presented.
    for (int i = 1; i <= 4; i++) wr(DW'(i), 1'b1);
    tick();
    tick();
    chk("stall_first", {16'h0, out_data}, 32'h1);
    cnt_v = 1;
    cnt2  = 0;
    for (int i = 1; i < 12; i++) begin
      tick();
      if (out_valid) cnt_v++;
      if (out_valid && out_data == 16'h2) cnt2++;
      out_stall = (i >= 1 && i <= 3);
    end
    chk("stall_hold_cycles", cnt2, 32'd4);
    chk("stall_valid_cycles", cnt_v, 32'd7);
    wait_drained("stall_drained");

    // Overflow with output disabled, then drain by flush.
    out_en = 1'b0;
    for (int i = 0; i < 8; i++) wr(DW'(16'h10 + i), 1'b1);
    chk("ovf_full", {31'h0, full}, 32'h1);
    chk("ovf_level8", {28'h0, level}, 32'h8);
    chk("ovf_not_yet", {31'h0, overflow}, 32'h0);
    wr(16'h55, 1'b0);
    chk("ovf_set", {31'h0, overflow}, 32'h1);
    chk("ovf_level_kept", {28'h0, level}, 32'h8);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);
    flush_pulse();
    wait_done("ovf_flush_done");
    wait_drained("ovf_drained");
    chk("ovf_level_after", {28'h0, level}, 32'h0);

    // Partial flush with a write landing during DRAIN.
    for (int i = 1; i <= 3; i++) wr(DW'(16'h20 + i), 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 16'h99;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("flush_last_valid", {31'h0, out_valid}, 32'h1);
    chk("flush_last_data", {16'h0, out_data}, 32'h23);
    chk("flush_done_early", {31'h0, flush_done}, 32'h0);
    tick();
    chk("flush_done_pulse", {31'h0, flush_done}, 32'h1);
    chk("flush_valid_off", {31'h0, out_valid}, 32'h0);
    tick();
    chk("flush_done_single", {31'h0, flush_done}, 32'h0);
    chk("flush_leftover", {28'h0, level}, 32'h1);
    exp_q.push_back(16'h99);
    flush_pulse();
    wait_done("leftover_flush_done");
    wait_drained("leftover_drained");

    // Empty flush.
    flush_pulse();
    chk("empty_flush_e0", {31'h0, flush_done}, 32'h0);
    tick();
    chk("empty_flush_e1", {31'h0, flush_done}, 32'h1);
    tick();
    chk("empty_flush_e2", {31'h0, flush_done}, 32'h0);

    // Back-to-back bursts separated by one idle cycle.
    for (int i = 1; i <= 8; i++) wr(DW'(16'h30 + i), 1'b1);
    out_en = 1'b1;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    hist[0] = out_valid;
    for (int k = 1; k < 10; k++) begin
      tick();
      hist[k] = out_valid;
    end
    chk("b2b_pattern", {22'h0, hist}, 32'h1EF);
    wait_drained("b2b_drained");

    // Reset in the middle of a burst with overflow set.
    out_en = 1'b0;
    for (int i = 0; i < 9; i++) wr(DW'(16'h40 + i), i < 8);
    out_en = 1'b1;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    @(negedge clk);
    #2;
    nRST = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_valid_neg", {31'h0, out_valid_neg}, 32'h0);
    chk("mid_rst_level", {28'h0, level}, 32'h0);
    chk("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    tick();
    tick();
    nRST = 1'b1;
    repeat (10) tick();
    chk("post_rst_level", {28'h0, level}, 32'h0);
    chk("post_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
